// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encodings, FSM states and helpers for the sequential ALU
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Encodings produced by the ALU control decoder
    localparam logic [2:0] ALU_SADD = 3'b000;
    localparam logic [2:0] ALU_SSUB = 3'b001;
    localparam logic [2:0] ALU_SMUL = 3'b010;
    localparam logic [2:0] ALU_SDIV = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_UADD = 3'b110;
    localparam logic [2:0] ALU_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        HALT = 2'd3
    } alu_state_t;

    // Two's-complement add overflow from the sign bits alone: operands agree
    // in sign and the sum does not. Subtract uses it with the B sign inverted.
    function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                          input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// rtl/seq_muldiv_core.sv - unsigned one-bit-per-cycle shift-add multiplier / restoring divider
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load          capture lo_init/b_init and mode, reset iteration counter to WIDTH-1
//   step          perform one iteration (multiply or divide step)
//   is_div        mode captured on load: 1 = divide, 0 = multiply
//   lo_init       multiplier (mul) or dividend (div) magnitude
//   b_init        multiplicand (mul) or divisor (div) magnitude
//   hi, lo        mul: {hi,lo} product; div: hi remainder, lo quotient
//   last          iteration counter is at 0 (the current step is the final one)
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] lo_init,
    input  logic [WIDTH-1:0] b_init,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift the
    // whole {carry,hi,lo} right so the product grows into hi from the top.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    // Restoring divide: shift the next dividend bit into the partial remainder.
    // The partial remainder is always below the divisor, so the subtraction
    // result fits in WIDTH bits whenever it is kept.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift[WIDTH-1:0] - b_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= lo_init;
            b_q   <= b_init;
            div_q <= is_div;
            cnt_q <= CW'(WIDTH - 1);
        end else if (step) begin
            if (div_q) begin
                hi_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], div_ge};
            end else begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/seq_alu_unit.sv
// rtl/seq_alu_unit.sv - execution-stage ALU with single-cycle logic/add ops and iterative signed mul/div
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   start            operation request, taken only in IDLE (not busy, not halted)
//   aluOp            operation select (see alu_pkg encodings)
//   opA, opB         signed operands (dividend/multiplicand, divisor/multiplier)
//   result           sum / low product / quotient
//   resultHi         high product / remainder, 0 for single-cycle ops
//   done             one-cycle completion pulse; result fields held until next done
//   busy             mul/div in progress
//   overflow         signed overflow of the last completed op
//   divByZero        last completed op was sdiv by zero
//   halted           sticky, set by the halt op, cleared only by reset
module seq_alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic             divByZero,
    output logic             halted
);

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_t state_q, state_d;

    logic             accept;
    logic             is_iter_op;
    logic             core_load, core_step, core_last;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] abs_a, abs_b;

    // Sign bookkeeping captured at accept time for the FIX cycle
    logic neg_main_q;
    logic neg_rem_q;
    logic is_div_q;
    logic div_ovf_q;

    logic [WIDTH-1:0] add_sum, sub_diff;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_ovf, sc_dbz;

    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic               mul_ovf;

    assign accept     = start && (state_q == IDLE);
    // Divide by zero never enters the iterative path
    assign is_iter_op = (aluOp == ALU_SMUL) || ((aluOp == ALU_SDIV) && (opB != '0));

    assign abs_a = opA[WIDTH-1] ? -opA : opA;
    assign abs_b = opB[WIDTH-1] ? -opB : opB;

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (aluOp == ALU_SDIV),
        .lo_init ((aluOp == ALU_SMUL) ? abs_b : abs_a),
        .b_init  ((aluOp == ALU_SMUL) ? abs_a : abs_b),
        .hi      (core_hi),
        .lo      (core_lo),
        .last    (core_last)
    );

    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (aluOp == ALU_HALT) begin
                        state_d = HALT;
                    end else if (is_iter_op) begin
                        state_d   = ITER;
                        core_load = 1'b1;
                    end
                end
            end
            ITER: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = FIX;
                end
            end
            FIX:  state_d = IDLE;
            HALT: state_d = HALT;
        endcase
    end

    assign add_sum  = opA + opB;
    assign sub_diff = opA - opB;

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        case (aluOp)
            ALU_SADD: begin
                sc_res = add_sum;
                sc_ovf = add_overflow(opA[WIDTH-1], opB[WIDTH-1], add_sum[WIDTH-1]);
            end
            ALU_SSUB: begin
                sc_res = sub_diff;
                sc_ovf = add_overflow(opA[WIDTH-1], ~opB[WIDTH-1], sub_diff[WIDTH-1]);
            end
            ALU_AND:  sc_res = opA & opB;
            ALU_OR:   sc_res = opA | opB;
            ALU_UADD: sc_res = add_sum;
            ALU_SDIV: begin
                // Only reached with opB == 0; nonzero divisors go iterative
                sc_res = '1;
                sc_hi  = opA;
                sc_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    // Sign correction of the unsigned core results
    assign prod_u  = {core_hi, core_lo};
    assign prod_s  = neg_main_q ? -prod_u : prod_u;
    assign quo_s   = neg_main_q ? -core_lo : core_lo;
    assign rem_s   = neg_rem_q ? -core_hi : core_hi;
    assign mul_ovf = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            result     <= '0;
            resultHi   <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            divByZero  <= 1'b0;
            halted     <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            div_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (accept) begin
                if (aluOp == ALU_HALT) begin
                    halted    <= 1'b1;
                    done      <= 1'b1;
                    overflow  <= 1'b0;
                    divByZero <= 1'b0;
                end else if (is_iter_op) begin
                    neg_main_q <= opA[WIDTH-1] ^ opB[WIDTH-1];
                    neg_rem_q  <= opA[WIDTH-1];
                    is_div_q   <= (aluOp == ALU_SDIV);
                    // MIN / -1: the magnitude path already yields MIN as quotient
                    div_ovf_q  <= (aluOp == ALU_SDIV) && (opA == SMIN) && (opB == '1);
                end else begin
                    result    <= sc_res;
                    resultHi  <= sc_hi;
                    overflow  <= sc_ovf;
                    divByZero <= sc_dbz;
                    done      <= 1'b1;
                end
            end else if (state_q == FIX) begin
                done      <= 1'b1;
                divByZero <= 1'b0;
                if (is_div_q) begin
                    result   <= quo_s;
                    resultHi <= rem_s;
                    overflow <= div_ovf_q;
                end else begin
                    result   <= prod_s[WIDTH-1:0];
                    resultHi <= prod_s[2*WIDTH-1:WIDTH];
                    overflow <= mul_ovf;
                end
            end
        end
    end

    assign busy = (state_q == ITER) || (state_q == FIX);

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb/tb_seq_alu_unit.sv - self-checking bench for seq_alu_unit with a reference arithmetic model
module tb_seq_alu_unit;
    import alu_pkg::*;

    localparam int W = 16;
    localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINS = -MAXS - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   aluOp;
    logic [W-1:0] opA, opB;
    logic [W-1:0] result, resultHi;
    logic         done, busy, overflow, divByZero, halted;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_hi  = '0;

    always #5 clk = ~clk;

    seq_alu_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .aluOp     (aluOp),
        .opA       (opA),
        .opB       (opB),
        .result    (result),
        .resultHi  (resultHi),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .divByZero (divByZero),
        .halted    (halted)
    );

    // Reference: plain signed integer arithmetic on 64-bit values
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic ov, output logic dz);
        longint sa, sb, t;
        sa = $signed(a);
        sb = $signed(b);
        r = '0; h = '0; ov = 1'b0; dz = 1'b0;
        case (op)
            ALU_SADD: begin t = sa + sb; r = t[W-1:0]; ov = (t > MAXS) || (t < MINS); end
            ALU_SSUB: begin t = sa - sb; r = t[W-1:0]; ov = (t > MAXS) || (t < MINS); end
            ALU_SMUL: begin
                t = sa * sb; r = t[W-1:0]; h = t[2*W-1:W]; ov = (t > MAXS) || (t < MINS);
            end
            ALU_SDIV: begin
                if (b == '0) begin
                    r = '1; h = a; dz = 1'b1;
                end else if (sa == MINS && sb == -1) begin
                    r = a; h = '0; ov = 1'b1;
                end else begin
                    t = sa / sb; r = t[W-1:0];
                    t = sa % sb; h = t[W-1:0];
                end
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_UADD: r = a + b;
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; aluOp = op; opA = a; opB = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic single_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input string name);
        logic [W-1:0] er, eh;
        logic eo, ed;
        model(op, a, b, er, eh, eo, ed);
        issue(op, a, b);
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL %s_handshake: done,busy=%b%b expected 10", name, done, busy);
        end
        checks++;
        if ({result, resultHi, overflow, divByZero} !== {er, eh, eo, ed}) begin
            failures++;
            $display("FAIL %s_fields: a=%h b=%h got res=%h hi=%h ov=%b dz=%b expected res=%h hi=%h ov=%b dz=%b",
                     name, a, b, result, resultHi, overflow, divByZero, er, eh, eo, ed);
        end
        last_res = er; last_hi = eh;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: done=%b expected 0", name, done);
        end
    endtask

    task automatic iter_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit inject, input string name);
        logic [W-1:0] er, eh;
        logic eo, ed;
        model(op, a, b, er, eh, eo, ed);
        issue(op, a, b);
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== {k <= W + 1, k == W + 2}) begin
                failures++;
                $display("FAIL %s_timing: cycle N+%0d busy,done=%b%b expected %b%b",
                         name, k, busy, done, k <= W + 1, k == W + 2);
            end
            if (k <= W + 1) begin
                checks++;
                if ({result, resultHi} !== {last_res, last_hi}) begin
                    failures++;
                    $display("FAIL %s_held: cycle N+%0d got %h_%h expected %h_%h",
                             name, k, resultHi, result, last_hi, last_res);
                end
            end
            start = inject && (k == 5);
            aluOp = ALU_SADD; opA = W'($urandom); opB = W'($urandom);
        end
        start = 1'b0;
        checks++;
        if ({result, resultHi, overflow, divByZero} !== {er, eh, eo, ed}) begin
            failures++;
            $display("FAIL %s_fields: a=%h b=%h got res=%h hi=%h ov=%b dz=%b expected res=%h hi=%h ov=%b dz=%b",
                     name, a, b, result, resultHi, overflow, divByZero, er, eh, eo, ed);
        end
        last_res = er; last_hi = eh;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL %s_after: done,busy=%b%b expected 00", name, done, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; aluOp = '0; opA = '0; opB = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({result, resultHi, done, busy, overflow, divByZero, halted} !== '0) begin
            failures++;
            $display("FAIL reset_state: res=%h hi=%h done=%b busy=%b ov=%b dz=%b halted=%b expected all 0",
                     result, resultHi, done, busy, overflow, divByZero, halted);
        end
        rst = 1'b1;
        last_res = '0; last_hi = '0;
    endtask

    task automatic test_single_cycle;
        logic [2:0] ops [5] = '{ALU_SADD, ALU_SSUB, ALU_AND, ALU_OR, ALU_UADD};
        single_op(ALU_SADD, 16'h7FFF, 16'h0001, "sadd_ovf");
        single_op(ALU_UADD, 16'hFFFF, 16'h0002, "uadd_wrap");
        single_op(ALU_AND,  16'hF0F0, 16'h3C3C, "and");
        single_op(ALU_SSUB, 16'h8000, 16'h0001, "ssub_ovf");
        for (int i = 0; i < 30; i++)
            single_op(ops[$urandom_range(0, 4)], pick_operand(), pick_operand(), "rand_single");
    endtask

    task automatic test_div_zero;
        single_op(ALU_SDIV, 16'h1234, 16'h0000, "sdiv_zero");
        single_op(ALU_SDIV, 16'h8000, 16'h0000, "sdiv_zero_min");
    endtask

    task automatic test_muldiv;
        iter_op(ALU_SMUL, 16'hFFFD, 16'h0007, 1'b1, "smul_m3x7");
        iter_op(ALU_SDIV, 16'hFFF9, 16'h0002, 1'b0, "sdiv_m7d2");
        iter_op(ALU_SDIV, 16'h8000, 16'hFFFF, 1'b1, "sdiv_min_m1");
        iter_op(ALU_SMUL, 16'h8000, 16'h8000, 1'b0, "smul_min_min");
        for (int i = 0; i < 10; i++)
            iter_op(ALU_SMUL, pick_operand(), pick_operand(), 1'b0, "rand_smul");
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] d;
            d = pick_operand();
            if (d == '0) d = 16'h0003;
            iter_op(ALU_SDIV, pick_operand(), d, 1'b0, "rand_sdiv");
        end
    endtask

    task automatic test_reset_mid_op;
        issue(ALU_SMUL, 16'hFFFD, 16'h0007);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({result, resultHi, done, busy, overflow, divByZero, halted} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op: res=%h hi=%h done=%b busy=%b ov=%b dz=%b halted=%b expected all 0",
                     result, resultHi, done, busy, overflow, divByZero, halted);
        end
        rst = 1'b1;
        last_res = '0; last_hi = '0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                failures++;
                $display("FAIL reset_abort: cycle %0d done,busy=%b%b expected 00", k, done, busy);
            end
        end
        single_op(ALU_SADD, 16'h1111, 16'h2222, "sadd_after_reset");
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [6] = '{ALU_SADD, ALU_SSUB, ALU_AND, ALU_OR, ALU_UADD, ALU_SDIV};
        logic [W-1:0] er, eh;
        logic eo, ed;
        logic [2:0] op;
        logic [W-1:0] a, b;
        er = '0; eh = '0; eo = 1'b0; ed = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({done, result, resultHi, overflow, divByZero} !== {1'b1, er, eh, eo, ed}) begin
                    failures++;
                    $display("FAIL b2b_%0d: done=%b res=%h hi=%h ov=%b dz=%b expected done=1 res=%h hi=%h ov=%b dz=%b",
                             i, done, result, resultHi, overflow, divByZero, er, eh, eo, ed);
                end
            end
            if (i < 8) begin
                op = ops[$urandom_range(0, 5)];
                a = pick_operand();
                b = (op == ALU_SDIV) ? '0 : pick_operand();
                model(op, a, b, er, eh, eo, ed);
                start = 1'b1; aluOp = op; opA = a; opB = b;
            end else begin
                start = 1'b0;
            end
        end
        last_res = er; last_hi = eh;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: done=%b expected 0", done);
        end
    endtask

    task automatic test_halt;
        issue(ALU_HALT, 16'hAAAA, 16'h5555);
        @(negedge clk);
        checks++;
        if ({done, halted, busy, result, resultHi} !== {3'b110, last_res, last_hi}) begin
            failures++;
            $display("FAIL halt_enter: done=%b halted=%b busy=%b res=%h hi=%h expected 1 1 0 %h %h",
                     done, halted, busy, result, resultHi, last_res, last_hi);
        end
        issue(ALU_SADD, 16'h0101, 16'h0202);
        issue(ALU_SMUL, 16'h0003, 16'h0003);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({done, halted, busy, result, resultHi} !== {3'b010, last_res, last_hi}) begin
                failures++;
                $display("FAIL halt_sticky: cycle %0d done=%b halted=%b busy=%b res=%h hi=%h expected 0 1 0 %h %h",
                         k, done, halted, busy, result, resultHi, last_res, last_hi);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({result, resultHi, done, busy, overflow, divByZero, halted} !== '0) begin
            failures++;
            $display("FAIL halt_reset: res=%h hi=%h done=%b busy=%b halted=%b expected all 0",
                     result, resultHi, done, busy, halted);
        end
        rst = 1'b1;
        last_res = '0; last_hi = '0;
        single_op(ALU_OR, 16'h00F0, 16'h0F00, "or_after_halt");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_cycle();
        test_div_zero();
        test_muldiv();
        test_reset_mid_op();
        test_back_to_back();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
